matrix_tile_scheduler: RTL and testbench

Sequences one matrix-vector product, out[n] = sum_k vec[k]*mat[k][n], with vector length K and N outputs, on the systolic PE array. The PE array holds at most PE_NUMBER k-rows, so the block splits K into tiles of up to PE_NUMBER rows and issues one job per tile to the array controller. Tile 0 overwrites the result; later tiles accumulate into it. The block sits between the host CSR bus and the array controller.

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/matrix_cfg_checker.sv | 28 ++
 rtl/matrix_tile_scheduler.sv | 146 ++++++++++++++
 tb/tb_matrix_tile_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: scheduler state encoding and tile job descriptor shared with the array controller.
package matrix_pkg;

    localparam int MAT_ADDR_W = 10;
    localparam int MAT_DIM_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT_DONE,
        FINISH
    } state_t;

    typedef struct packed {
        logic [MAT_DIM_W-1:0]  rows;
        logic [MAT_DIM_W-1:0]  cols;
        logic [MAT_ADDR_W-1:0] vec_addr;
        logic [MAT_ADDR_W-1:0] mat_addr;
        logic [MAT_ADDR_W-1:0] res_addr;
        logic                  accum;
    } job_t;

    function automatic logic [MAT_DIM_W-1:0] tile_rows(input logic [MAT_DIM_W-1:0] k, input int pe);
        return (k > MAT_DIM_W'(pe)) ? MAT_DIM_W'(pe) : k;
    endfunction

endpackage

// File: rtl/matrix_cfg_checker.sv
// matrix_cfg_checker: rejects empty descriptors and any operand or result region running past the end of local memory.
module matrix_cfg_checker #(
    parameter int ADDR_SIZE = 10,
    parameter int DIM_W     = 8
) (
    input  logic [DIM_W-1:0]     k,
    input  logic [DIM_W-1:0]     n,
    input  logic [ADDR_SIZE-1:0] vec_base,
    input  logic [ADDR_SIZE-1:0] mat_base,
    input  logic [ADDR_SIZE-1:0] res_base,
    output logic                 reject
);

    localparam int W = ADDR_SIZE + 2 * DIM_W;

    logic [W-1:0] lim;
    logic [W-1:0] vec_end;
    logic [W-1:0] mat_end;
    logic [W-1:0] res_end;

    // Wide enough that base + K*N cannot wrap.
    assign lim     = W'(1) << ADDR_SIZE;
    assign vec_end = W'(vec_base) + W'(k);
    assign mat_end = W'(mat_base) + W'(k) * W'(n);
    assign res_end = W'(res_base) + W'(n);
    assign reject  = (k == '0) || (n == '0) || (vec_end > lim) || (mat_end > lim) || (res_end > lim);

endmodule

// File: rtl/matrix_tile_scheduler.sv
// matrix_tile_scheduler: splits a K x N matrix-vector product into PE_NUMBER-row tiles
// and hands one job per tile to the systolic array controller.
module matrix_tile_scheduler
    import matrix_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int PE_NUMBER = 64,
    parameter int DIM_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DIM_W-1:0]     cfg_k,
    input  logic [DIM_W-1:0]     cfg_n,
    input  logic [ADDR_SIZE-1:0] cfg_vec_base,
    input  logic [ADDR_SIZE-1:0] cfg_mat_base,
    input  logic [ADDR_SIZE-1:0] cfg_res_base,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 aborted,
    output logic                 job_valid,
    input  logic                 job_ready,
    output logic [DIM_W-1:0]     job_rows,
    output logic [DIM_W-1:0]     job_cols,
    output logic [ADDR_SIZE-1:0] job_vec_addr,
    output logic [ADDR_SIZE-1:0] job_mat_addr,
    output logic [ADDR_SIZE-1:0] job_res_addr,
    output logic                 job_accum,
    input  logic                 job_done
);

    localparam logic [DIM_W-1:0] PE = DIM_W'(PE_NUMBER);

    state_t               state;
    job_t                 job;
    logic [DIM_W-1:0]     d_k;
    logic [DIM_W-1:0]     d_n;
    logic [ADDR_SIZE-1:0] d_vec;
    logic [ADDR_SIZE-1:0] d_mat;
    logic [ADDR_SIZE-1:0] d_res;
    logic [DIM_W-1:0]     rem_k;
    logic [DIM_W-1:0]     rem_next;
    logic [ADDR_SIZE-1:0] stride;
    logic                 abort_pending;
    logic                 stop;
    logic                 reject;

    matrix_cfg_checker #(
        .ADDR_SIZE(ADDR_SIZE),
        .DIM_W    (DIM_W)
    ) u_checker (
        .k       (d_k),
        .n       (d_n),
        .vec_base(d_vec),
        .mat_base(d_mat),
        .res_base(d_res),
        .reject  (reject)
    );

    assign cfg_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign job_valid    = (state == ISSUE);
    assign job_rows     = job.rows;
    assign job_cols     = job.cols;
    assign job_vec_addr = job.vec_addr;
    assign job_mat_addr = job.mat_addr;
    assign job_res_addr = job.res_addr;
    assign job_accum    = job.accum;
    assign rem_next     = rem_k - PE;
    // An abort landing on the same cycle as job_done still ends the run.
    assign stop         = abort_pending | abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            done          <= 1'b0;
            err           <= 1'b0;
            aborted       <= 1'b0;
            abort_pending <= 1'b0;
            job           <= '0;
            d_k           <= '0;
            d_n           <= '0;
            d_vec         <= '0;
            d_mat         <= '0;
            d_res         <= '0;
            rem_k         <= '0;
            stride        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    d_k           <= cfg_k;
                    d_n           <= cfg_n;
                    d_vec         <= cfg_vec_base;
                    d_mat         <= cfg_mat_base;
                    d_res         <= cfg_res_base;
                    err           <= 1'b0;
                    aborted       <= 1'b0;
                    abort_pending <= 1'b0;
                    state         <= CHECK;
                end
                CHECK: if (reject) begin
                    err   <= 1'b1;
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    rem_k  <= d_k;
                    stride <= ADDR_SIZE'(PE_NUMBER * int'(d_n));
                    job    <= '{rows: tile_rows(d_k, PE_NUMBER), cols: d_n, vec_addr: d_vec,
                                mat_addr: d_mat, res_addr: d_res, accum: 1'b0};
                    state  <= ISSUE;
                end
                ISSUE: if (job_ready) begin
                    state <= WAIT_DONE;
                end else if (abort) begin
                    aborted <= 1'b1;
                    done    <= 1'b1;
                    state   <= FINISH;
                end
                WAIT_DONE: begin
                    if (abort) abort_pending <= 1'b1;
                    if (job_done) begin
                        if (rem_k <= PE || stop) begin
                            aborted <= stop;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            rem_k        <= rem_next;
                            job.vec_addr <= job.vec_addr + ADDR_SIZE'(PE_NUMBER);
                            job.mat_addr <= job.mat_addr + stride;
                            job.rows     <= tile_rows(rem_next, PE_NUMBER);
                            job.accum    <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_tile_scheduler.sv
// tb_matrix_tile_scheduler: drives descriptors and a randomised array controller,
// checking every job against tile lists computed from K, N and the base addresses.
module tb_matrix_tile_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_k = '0;
    logic [7:0] cfg_n = '0;
    logic [9:0] cfg_vec_base = '0;
    logic [9:0] cfg_mat_base = '0;
    logic [9:0] cfg_res_base = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic       aborted;
    logic       job_valid;
    logic       job_ready = 1'b0;
    logic [7:0] job_rows;
    logic [7:0] job_cols;
    logic [9:0] job_vec_addr;
    logic [9:0] job_mat_addr;
    logic [9:0] job_res_addr;
    logic       job_accum;
    logic       job_done = 1'b0;
    logic [63:0] obs;

    int checks = 0;
    int errors = 0;

    matrix_tile_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_k       (cfg_k),
        .cfg_n       (cfg_n),
        .cfg_vec_base(cfg_vec_base),
        .cfg_mat_base(cfg_mat_base),
        .cfg_res_base(cfg_res_base),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .aborted     (aborted),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_rows    (job_rows),
        .job_cols    (job_cols),
        .job_vec_addr(job_vec_addr),
        .job_mat_addr(job_mat_addr),
        .job_res_addr(job_res_addr),
        .job_accum   (job_accum),
        .job_done    (job_done)
    );

    always #5 clk = ~clk;

    assign obs = {17'b0, job_rows, job_cols, job_vec_addr, job_mat_addr, job_res_addr, job_accum};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int rows, input int cols, input int vec, input int mat,
                                       input int res, input int acc);
        return {17'b0, 8'(rows), 8'(cols), 10'(vec), 10'(mat), 10'(res), 1'(acc)};
    endfunction

    task automatic present(input int k, input int n, input int vec, input int mat, input int res);
        @(negedge clk);
        chk("cfg_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_k = 8'(k);
        cfg_n = 8'(n);
        cfg_vec_base = 10'(vec);
        cfg_mat_base = 10'(mat);
        cfg_res_base = 10'(res);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("check_busy", {busy, job_valid, done}, 3'b100);
        chk("check_flags_clear", {err, aborted}, 2'b00);
        @(negedge clk);
    endtask

    // abort_tile < 0: never abort; hold2 >= 0: fixed job_ready stall on the second tile.
    task automatic run(input int k, input int n, input int vec, input int mat, input int res,
                       input int abort_tile, input int hold2);
        bit rej;
        int tiles;
        bit stop;
        bit exp_ab;
        int hold;
        logic [63:0] exp;
        rej = (k == 0) || (n == 0) || (vec + k > 1024) || (mat + k * n > 1024) || (res + n > 1024);
        tiles = (k + 63) / 64;
        exp_ab = 1'b0;
        present(k, n, vec, mat, res);
        if (rej) begin
            chk("reject_done", {done, err, aborted, job_valid}, 4'b1100);
        end else begin
            stop = 1'b0;
            for (int t = 0; t < tiles && !stop; t++) begin
                exp = pk((k - 64 * t > 64) ? 64 : k - 64 * t, n, vec + 64 * t, mat + 64 * t * n, res, t > 0);
                hold = (t == 1 && hold2 >= 0) ? hold2 : int'($urandom_range(0, 3));
                for (int i = 0; i < hold; i++) begin
                    chk("stall_valid", job_valid, 1);
                    chk("stall_fields", obs, exp);
                    @(negedge clk);
                end
                chk("job_valid", job_valid, 1);
                chk("job_fields", obs, exp);
                job_ready = 1'b1;
                @(negedge clk);
                job_ready = 1'b0;
                chk("wait_no_valid", {job_valid, done}, 2'b00);
                if (t == abort_tile) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    exp_ab = 1'b1;
                end
                repeat ($urandom_range(0, 4)) @(negedge clk);
                job_done = 1'b1;
                @(negedge clk);
                job_done = 1'b0;
                stop = (t == tiles - 1) || exp_ab;
                if (stop) chk("run_done", {done, aborted, err, job_valid}, {1'b1, exp_ab, 2'b00});
            end
        end
        @(negedge clk);
        chk("back_idle", {cfg_ready, busy, done}, 3'b100);
        chk("flags_hold", {err, aborted}, {rej, exp_ab});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {cfg_ready, busy, job_valid, done, err, aborted}, 6'b100000);
        chk("reset_fields", obs, 64'd0);
        reset_n = 1'b1;

        run(40, 16, 'h010, 'h100, 'h300, -1, -1);
        run(150, 4, 'h000, 'h040, 'h000, -1, -1);
        run(128, 2, 'h000, 'h000, 'h200, -1, 5);
        run(0, 8, 0, 0, 0, -1, -1);
        run(8, 0, 0, 0, 0, -1, -1);
        run(4, 8, 0, 'h3F0, 0, -1, -1);
        run(4, 8, 0, 'h3E0, 0, -1, -1);
        run(10, 10, 'h3F7, 0, 0, -1, -1);
        run(10, 10, 0, 0, 'h3F7, -1, -1);
        run(150, 4, 'h000, 'h040, 'h000, 0, -1);

        // Abort while the first job is still waiting for job_ready.
        present(40, 16, 'h010, 'h100, 'h300);
        chk("issue_before_abort", job_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("issue_abort_done", {done, aborted, err, job_valid}, 4'b1100);
        @(negedge clk);
        chk("issue_abort_idle", {cfg_ready, done, aborted}, 3'b101);

        // Reset in the middle of a run drops it silently.
        present(150, 4, 0, 'h040, 0);
        chk("pre_reset_valid", job_valid, 1);
        #2 reset_n = 1'b0;
        #1 chk("reset_midrun", {job_valid, cfg_ready, busy, done}, 4'b0100);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy}, 2'b00);
        end

        for (int r = 0; r < 40; r++) begin
            run(int'($urandom_range(0, 200)), int'($urandom_range(0, 12)), int'($urandom_range(0, 300)),
                int'($urandom_range(0, 500)), int'($urandom_range(0, 1023)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
